// File: rtl/jtpang_pal_dma.sv
// Palette RAM CPU-port arbiter with a bank fill/copy engine for the Pang video board.
// Z80 accesses always win the port; the engine stalls, and in copy mode it re-reads after a stolen write.
module jtpang_pal_dma (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pal_cs,
    input  logic        wr_n,
    input  logic        pal_bank,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  pal_dout,
    input  logic        dma_start,
    input  logic        dma_copy,
    input  logic        dma_bank,
    input  logic [7:0]  dma_val,
    output logic        busy,
    output logic        done,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_q
);
    // state | meaning
    // IDLE  | waiting for dma_start; CPU owns the port
    // FILL  | writing val_q to {cnt[10], bank, cnt[9:0]}
    // RD    | copy: addressing the source byte
    // WR    | copy: writing ram_q into the opposite bank
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        copy_q, copy_d;
    logic        bank_q, bank_d;
    logic [7:0]  val_q, val_d;
    logic        busy_q, done_q;
    logic        last;
    logic        eng_bank;
    logic [11:0] cpu_map;
    logic [11:0] eng_addr;

    assign last     = (cnt_q == 11'h7FF);
    assign cpu_map  = {cpu_addr[0], pal_bank, cpu_addr[10:1]};
    assign eng_bank = (copy_q && state_q == S_WR) ? ~bank_q : bank_q;
    assign eng_addr = {cnt_q[10], eng_bank, cnt_q[9:0]};
    assign pal_dout = ram_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        copy_d  = copy_q;
        bank_d  = bank_q;
        val_d   = val_q;
        case (state_q)
            S_IDLE: begin
                if (dma_start) begin
                    copy_d  = dma_copy;
                    bank_d  = dma_bank;
                    val_d   = dma_val;
                    cnt_d   = '0;
                    state_d = dma_copy ? S_RD : S_FILL;
                end
            end
            S_FILL: begin
                if (!pal_cs) begin
                    if (last) state_d = S_DONE;
                    else      cnt_d   = cnt_q + 11'd1;
                end
            end
            S_RD: begin
                if (!pal_cs) state_d = S_WR;
            end
            S_WR: begin
                // A stolen WR cycle leaves ram_q holding the CPU's data, so re-read the same cnt
                if (pal_cs) begin
                    state_d = S_RD;
                end else if (last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 11'd1;
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            copy_q  <= 1'b0;
            bank_q  <= 1'b0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            copy_q  <= copy_d;
            bank_q  <= bank_d;
            val_q   <= val_d;
            busy_q  <= (state_d == S_FILL) || (state_d == S_RD) || (state_d == S_WR);
            done_q  <= (state_d == S_DONE);
        end
    end

    always_comb begin
        ram_addr = cpu_map;
        ram_din  = 8'h00;
        ram_we   = 1'b0;
        if (pal_cs) begin
            ram_din = cpu_dout;
            ram_we  = ~wr_n;
        end else begin
            case (state_q)
                S_FILL: begin
                    ram_addr = eng_addr;
                    ram_din  = val_q;
                    ram_we   = 1'b1;
                end
                S_RD: ram_addr = eng_addr;
                S_WR: begin
                    ram_addr = eng_addr;
                    ram_din  = ram_q;
                    ram_we   = 1'b1;
                end
                default: ram_we = 1'b0;
            endcase
        end
        if (!rst_n) begin
            ram_we  = 1'b0;
            ram_din = 8'h00;
        end
    end

endmodule
